// File: rtl/oam_dma_arbiter_pkg.sv
// Shared definitions for the OAM-DMA arbiter slice.
//   dma_state_e  : sequencer states (idle, one-M-cycle start delay, copying)
//   DMA_LEN      : bytes per transfer, also the OAM index limit
//   DMA_REG_ADDR : CPU address of the DMA source register
//   T_COMMIT     : T-cycle on which M-cycle effects commit
//   dma_src_hi   : source high byte with the echo-RAM region folded down
package oam_dma_arbiter_pkg;

  localparam int          DMA_LEN      = 160;
  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
  localparam logic [1:0]  T_COMMIT     = 2'd3;

  typedef enum logic [1:0] {
    DMA_IDLE,
    DMA_START,
    DMA_ACTIVE
  } dma_state_e;

  // E000-FFFF mirrors C000-DFFF, so clearing bit 5 maps Ex onto Cx.
  function automatic logic [7:0] dma_src_hi(input logic [7:0] reg_val);
    return (reg_val >= 8'hE0) ? (reg_val & 8'hDF) : reg_val;
  endfunction

endpackage

// File: rtl/oam_dma_arbiter_dma_sequencer.sv
// DMA sequencer: state machine, byte index and bus-blocking flag.
//   clk, reset  : clock, synchronous active-high reset
//   t_cycle     : T-cycle within the current M-cycle (commits on 3)
//   trigger     : CPU wrote the DMA register this M-cycle (valid on t3)
//   xfer_valid  : a byte is being copied this M-cycle
//   index       : OAM index / source low byte of the current byte
//   dma_active  : the DMA owns the external bus
module oam_dma_arbiter_dma_sequencer
  import oam_dma_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] t_cycle,
  input  logic       trigger,
  output logic       xfer_valid,
  output logic [7:0] index,
  output logic       dma_active
);

  localparam logic [7:0] LAST_INDEX = 8'(DMA_LEN - 1);

  dma_state_e state_q, state_d;
  logic [7:0] index_q, index_d;
  logic       block_q, block_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= DMA_IDLE;
      index_q <= 8'd0;
      block_q <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      block_q <= block_d;
    end
  end

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    block_d = block_q;
    if (t_cycle == T_COMMIT) begin
      unique case (state_q)
        DMA_IDLE: begin
          if (trigger) begin
            state_d = DMA_START;
            block_d = 1'b0;
          end
        end
        DMA_START: begin
          // A retrigger simply restarts the delay; the flag is kept so a
          // start that interrupted a transfer keeps the bus locked.
          if (!trigger) begin
            state_d = DMA_ACTIVE;
            index_d = 8'd0;
          end
        end
        DMA_ACTIVE: begin
          // Trigger wins over end-of-transfer; the current byte is still
          // written because oam_we does not depend on the next state.
          if (trigger) begin
            state_d = DMA_START;
            index_d = 8'd0;
            block_d = 1'b1;
          end else if (index_q == LAST_INDEX) begin
            state_d = DMA_IDLE;
            index_d = 8'd0;
            block_d = 1'b0;
          end else begin
            index_d = index_q + 8'd1;
          end
        end
        default: begin
          state_d = DMA_IDLE;
          index_d = 8'd0;
          block_d = 1'b0;
        end
      endcase
    end
  end

  assign xfer_valid = (state_q == DMA_ACTIVE);
  assign index      = index_q;
  assign dma_active = (state_q == DMA_ACTIVE) || ((state_q == DMA_START) && block_q);

endmodule

// File: rtl/oam_dma_arbiter.sv
// OAM-DMA register owner and external-bus arbiter.
//   clk, reset           : clock, synchronous active-high reset
//   t_cycle              : T-cycle within the M-cycle (commits on 3)
//   cpu_mem_* / cpu_addr : CPU memory port in; cpu_rdata returned
//   bus_*                : external bus (0000-FEFF), shared CPU/DMA
//   hi_*                 : high page FF00-FFFF except the DMA register
//   oam_we/addr/wdata    : OAM write port driven by the DMA
//   dma_active           : DMA currently owns the external bus
module oam_dma_arbiter
  import oam_dma_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  t_cycle,
  input  logic        cpu_mem_enable,
  input  logic        cpu_mem_write,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        bus_enable,
  output logic        bus_write,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata,
  output logic        hi_enable,
  output logic        hi_write,
  input  logic [7:0]  hi_rdata,
  output logic        oam_we,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_wdata,
  output logic        dma_active
);

  logic        reg_hit, hi_hit, ext_hit;
  logic        trigger;
  logic [7:0]  dma_reg_q, dma_reg_d;
  logic        xfer_valid;
  logic [7:0]  index;
  logic [15:0] src_addr;

  always_comb begin
    reg_hit = (cpu_addr == DMA_REG_ADDR);
    hi_hit  = (cpu_addr[15:8] == 8'hFF) && !reg_hit;
    ext_hit = !reg_hit && !hi_hit;
    trigger = (t_cycle == T_COMMIT) && cpu_mem_enable && cpu_mem_write && reg_hit;
  end

  always_comb begin
    dma_reg_d = dma_reg_q;
    if (trigger) dma_reg_d = cpu_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) dma_reg_q <= 8'hFF;
    else       dma_reg_q <= dma_reg_d;
  end

  oam_dma_arbiter_dma_sequencer u_seq (
    .clk        (clk),
    .reset      (reset),
    .t_cycle    (t_cycle),
    .trigger    (trigger),
    .xfer_valid (xfer_valid),
    .index      (index),
    .dma_active (dma_active)
  );

  assign src_addr = {dma_src_hi(dma_reg_q), index};

  // While the DMA owns the bus the CPU is cut off completely: its writes
  // vanish and the bus shows only the DMA read (or nothing during a
  // blocked start).
  always_comb begin
    bus_enable = 1'b0;
    bus_write  = 1'b0;
    bus_addr   = cpu_addr;
    bus_wdata  = cpu_wdata;
    if (dma_active) begin
      bus_enable = xfer_valid;
      bus_addr   = src_addr;
      bus_wdata  = 8'h00;
    end else begin
      bus_enable = cpu_mem_enable && ext_hit;
      bus_write  = cpu_mem_enable && cpu_mem_write && ext_hit;
    end
  end

  // High page is never blocked so HRAM/IO stay usable during DMA.
  always_comb begin
    hi_enable = cpu_mem_enable && hi_hit;
    hi_write  = cpu_mem_enable && cpu_mem_write && hi_hit;
  end

  always_comb begin
    if (reg_hit)                    cpu_rdata = dma_reg_q;
    else if (hi_hit)                cpu_rdata = hi_rdata;
    else if (dma_active && ext_hit) cpu_rdata = 8'hFF;
    else                            cpu_rdata = bus_rdata;
  end

  always_comb begin
    oam_we    = xfer_valid && (t_cycle == T_COMMIT);
    oam_addr  = index;
    oam_wdata = bus_rdata;
  end

endmodule
